// File: rtl/ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: FSM states, read tag and
// the round-robin pointer width helper.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } arb_state_e;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_IDX_W = 3;

  typedef struct packed {
    logic                 rd;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  function automatic int rr_idx_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational requester picker: round-robin starting after ptr_i, or fixed
// priority (lowest index wins) when RAM_SP_ARBITER_FIXED_PRIO_EN is defined.
module ram_arb_rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = rr_idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o
);

  logic found;

`ifdef RAM_SP_ARBITER_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    if (en_i) begin
`ifdef RAM_SP_ARBITER_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) begin
        if (!found && valid_i[i]) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
`else
      // Distance k from the pointer sets priority; exactly one i matches each k.
      for (int k = 1; k <= NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!found && valid_i[i] && (ptr_i == PW'((i - k + NREQ) % NREQ))) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
          end
        end
      end
`endif
    end
  end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Shares one single-port synchronous RAM between NREQ requesters with a
// run/drain/halt FSM; RAM_SP_ARBITER_FIXED_PRIO_EN selects fixed priority.
module ram_sp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 6,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arb_en,
  output logic               halted,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               ram_we,
  output logic               ram_rst,
  output logic [AW-1:0]      ram_a,
  output logic [DW-1:0]      ram_di,
  input  logic [DW-1:0]      ram_do
);

  localparam int PW = rr_idx_w(NREQ);

  // Handshake: a command transfers in the cycle req_valid[i] & req_ready[i];
  // req_ready is one-hot, never raised without valid, and valid may drop freely.
  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant;
  logic            arb_go, accept, pipe_empty;
  logic [PW-1:0]   ptr, sel_idx;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            cmd_vld_q, ram_we_q, ram_rst_q;
  logic [AW-1:0]   ram_a_q;
  logic [DW-1:0]   ram_di_q;
  tag_t            tag1_q, tag2_q;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q;

  assign arb_go = (state_q == ST_RUN) && arb_en && !rst;

`ifdef RAM_SP_ARBITER_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PW-1:0] ptr_q;
  assign ptr = ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr_q <= PW'(NREQ - 1);
    else if (accept) ptr_q <= sel_idx;
  end
`endif

  ram_arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr),
    .en_i    (arb_go),
    .grant_o (grant)
  );

  always_comb begin
    sel_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_idx   = PW'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  assign accept = |(grant & req_valid);

  // ram_rst keeps the RAM output register at zero except on read commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_vld_q <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_rst_q <= 1'b1;
      ram_a_q   <= '0;
      ram_di_q  <= '0;
      tag1_q    <= '0;
      tag2_q    <= '0;
    end else begin
      cmd_vld_q  <= accept;
      ram_we_q   <= accept & sel_we;
      ram_rst_q  <= ~(accept & ~sel_we);
      if (accept) begin
        ram_a_q  <= sel_addr;
        ram_di_q <= sel_wdata;
      end
      tag1_q.rd  <= accept & ~sel_we;
      tag1_q.idx <= TAG_IDX_W'(sel_idx);
      tag2_q     <= tag1_q;
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid_d[i] = tag2_q.rd && (tag2_q.idx == TAG_IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (tag2_q.rd) rsp_data_q <= ram_do;
    end
  end

  assign pipe_empty = !cmd_vld_q && !tag1_q.rd && !tag2_q.rd;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (!arb_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (arb_en)          state_d = ST_RUN;
        else if (pipe_empty) state_d = ST_HALTED;
      end
      ST_HALTED: if (arb_en) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  assign halted    = (state_q == ST_HALTED);
  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign ram_we    = ram_we_q;
  assign ram_rst   = ram_rst_q;
  assign ram_a     = ram_a_q;
  assign ram_di    = ram_di_q;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed, table-driven bench for ram_sp_arbiter with a behavioural
// read-first single-port RAM; handles both priority builds.
module tb_ram_sp_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 6;
  localparam int DW   = 16;
  localparam int NROWS = 20;

`ifdef RAM_SP_ARBITER_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, arb_en, halted;
  logic [NREQ-1:0] req_valid, req_we, req_ready, rsp_valid;
  logic [AW-1:0]   a0, a1;
  logic [DW-1:0]   d0, d1;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, ram_di;
  logic [DW-1:0]   ram_do = '0;
  logic            ram_we, ram_rst;
  logic [AW-1:0]   ram_a;

  int n_checks = 0;
  int n_fail   = 0;

  assign req_addr  = {a1, a0};
  assign req_wdata = {d1, d0};

  always #5 clk = ~clk;

  ram_sp_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .halted    (halted),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_we    (ram_we),
    .ram_rst   (ram_rst),
    .ram_a     (ram_a),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  // Single-port RAM: read-first, registered output with synchronous reset.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    if (ram_rst) ram_do <= '0;
    else         ram_do <= mem[ram_a];
  end

  typedef struct {
    logic [1:0]  valid, we;
    logic [5:0]  a0, a1;
    logic [15:0] d0, d1;
    logic [1:0]  exp_ready, exp_rsp;
    logic        chk_data;
    logic [15:0] exp_data;
    logic        chk_ram, exp_we, exp_rst;
    logic [5:0]  exp_a;
    logic [15:0] exp_di;
  } vec_t;

  vec_t tbl [NROWS];

  task automatic row(input int k, input logic [1:0] valid, input logic [1:0] we,
                     input logic [5:0] ra0, input logic [5:0] ra1,
                     input logic [15:0] rd0, input logic [15:0] rd1,
                     input logic [1:0] er, input logic [1:0] ersp,
                     input logic cd, input logic [15:0] ed,
                     input logic cr, input logic ewe, input logic erst,
                     input logic [5:0] ea, input logic [15:0] edi);
    tbl[k].valid = valid;   tbl[k].we = we;
    tbl[k].a0 = ra0;        tbl[k].a1 = ra1;
    tbl[k].d0 = rd0;        tbl[k].d1 = rd1;
    tbl[k].exp_ready = er;  tbl[k].exp_rsp = ersp;
    tbl[k].chk_data = cd;   tbl[k].exp_data = ed;
    tbl[k].chk_ram = cr;    tbl[k].exp_we = ewe;
    tbl[k].exp_rst = erst;  tbl[k].exp_a = ea;
    tbl[k].exp_di = edi;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] valid, input logic [1:0] we,
                       input logic [5:0] ra0, input logic [5:0] ra1,
                       input logic [15:0] rd0, input logic [15:0] rd1);
    req_valid = valid; req_we = we;
    a0 = ra0; a1 = ra1; d0 = rd0; d1 = rd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, req_ready, 2'b00);
    check({tag, " rsp_valid"}, rsp_valid, 2'b00);
    check({tag, " rsp_data"},  rsp_data, 16'h0);
    check({tag, " ram_we"},    ram_we, 1'b0);
    check({tag, " ram_rst"},   ram_rst, 1'b1);
    check({tag, " ram_a"},     ram_a, 6'd0);
    check({tag, " ram_di"},    ram_di, 16'h0);
    check({tag, " halted"},    halted, 1'b0);
  endtask

  initial begin
    // k  valid  we     a0     a1     d0        d1        ready  rsp    cd  data  cr we rst a di
    row(0,  2'b01, 2'b01, 6'd5, 6'd0, 16'hBEEF, 16'h0,    2'b01, 2'b00, 0, 16'h0,    0, 0, 0, 6'd0, 16'h0);
    row(1,  2'b01, 2'b00, 6'd5, 6'd0, 16'h0,    16'h0,    2'b01, 2'b00, 0, 16'h0,    1, 1, 1, 6'd5, 16'hBEEF);
    row(2,  2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, 2'b00, 0, 16'h0,    1, 0, 0, 6'd5, 16'h0);
    row(3,  2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, 2'b00, 0, 16'h0,    1, 0, 1, 6'd5, 16'h0);
    row(4,  2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, 2'b01, 1, 16'hBEEF, 0, 0, 0, 6'd0, 16'h0);
    row(5,  2'b01, 2'b01, 6'd1, 6'd0, 16'h1111, 16'h0,    2'b01, 2'b00, 1, 16'hBEEF, 0, 0, 0, 6'd0, 16'h0);
    row(6,  2'b10, 2'b10, 6'd0, 6'd2, 16'h0,    16'h2222, 2'b10, 2'b00, 0, 16'h0,    1, 1, 1, 6'd1, 16'h1111);
    row(7,  2'b11, 2'b00, 6'd1, 6'd2, 16'h0,    16'h0,    2'b01, 2'b00, 0, 16'h0,    1, 1, 1, 6'd2, 16'h2222);
    row(8,  2'b11, 2'b00, 6'd1, 6'd2, 16'h0,    16'h0,    FP ? 2'b01 : 2'b10, 2'b00, 0, 16'h0, 1, 0, 0, 6'd1, 16'h0);
    row(9,  2'b11, 2'b00, 6'd1, 6'd2, 16'h0,    16'h0,    2'b01, 2'b00, 0, 16'h0,    0, 0, 0, 6'd0, 16'h0);
    row(10, 2'b11, 2'b00, 6'd1, 6'd2, 16'h0,    16'h0,    FP ? 2'b01 : 2'b10, 2'b01, 1, 16'h1111, 0, 0, 0, 6'd0, 16'h0);
    row(11, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, FP ? 2'b01 : 2'b10,
        1, FP ? 16'h1111 : 16'h2222, 1, 0, 0, FP ? 6'd1 : 6'd2, 16'h0);
    row(12, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, 2'b01, 1, 16'h1111,
        1, 0, 1, FP ? 6'd1 : 6'd2, 16'h0);
    row(13, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, FP ? 2'b01 : 2'b10,
        1, FP ? 16'h1111 : 16'h2222, 0, 0, 0, 6'd0, 16'h0);
    row(14, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, 2'b00,
        1, FP ? 16'h1111 : 16'h2222, 0, 0, 0, 6'd0, 16'h0);
    row(15, 2'b10, 2'b10, 6'd0, 6'd9, 16'h0,    16'h00AA, 2'b10, 2'b00, 0, 16'h0,    0, 0, 0, 6'd0, 16'h0);
    row(16, 2'b10, 2'b00, 6'd0, 6'd9, 16'h0,    16'h0,    2'b10, 2'b00, 0, 16'h0,    1, 1, 1, 6'd9, 16'h00AA);
    row(17, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, 2'b00, 0, 16'h0,    1, 0, 0, 6'd9, 16'h0);
    row(18, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, 2'b00, 0, 16'h0,    1, 0, 1, 6'd9, 16'h0);
    row(19, 2'b00, 2'b00, 6'd0, 6'd0, 16'h0,    16'h0,    2'b00, 2'b10, 1, 16'h00AA, 0, 0, 0, 6'd0, 16'h0);

    rst    = 1'b1;
    arb_en = 1'b1;
    drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst = 1'b0;

    for (int k = 0; k < NROWS; k++) begin
      step();
      drive(tbl[k].valid, tbl[k].we, tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1);
      @(negedge clk);
      check($sformatf("row%0d req_ready", k), req_ready, tbl[k].exp_ready);
      check($sformatf("row%0d rsp_valid", k), rsp_valid, tbl[k].exp_rsp);
      if (tbl[k].chk_data) check($sformatf("row%0d rsp_data", k), rsp_data, tbl[k].exp_data);
      if (tbl[k].chk_ram) begin
        check($sformatf("row%0d ram_we", k),  ram_we,  tbl[k].exp_we);
        check($sformatf("row%0d ram_rst", k), ram_rst, tbl[k].exp_rst);
        check($sformatf("row%0d ram_a", k),   ram_a,   tbl[k].exp_a);
        if (tbl[k].exp_we) check($sformatf("row%0d ram_di", k), ram_di, tbl[k].exp_di);
      end
    end

    // Drain with two reads in flight, then resume.
    step();
    drive(2'b11, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
    @(negedge clk);
    check("drain d0 req_ready", req_ready, 2'b01);
    step();
    @(negedge clk);
    check("drain d1 req_ready", req_ready, FP ? 2'b01 : 2'b10);
    step();
    arb_en = 1'b0;
    @(negedge clk);
    check("drain d2 req_ready", req_ready, 2'b00);
    check("drain d2 halted", halted, 1'b0);
    step();
    @(negedge clk);
    check("drain d3 rsp_valid", rsp_valid, 2'b01);
    check("drain d3 rsp_data", rsp_data, 16'h1111);
    check("drain d3 halted", halted, 1'b0);
    step();
    @(negedge clk);
    check("drain d4 rsp_valid", rsp_valid, FP ? 2'b01 : 2'b10);
    check("drain d4 rsp_data", rsp_data, FP ? 16'h1111 : 16'h2222);
    check("drain d4 halted", halted, 1'b0);
    step();
    @(negedge clk);
    check("drain d5 halted", halted, 1'b1);
    check("drain d5 req_ready", req_ready, 2'b00);
    check("drain d5 rsp_valid", rsp_valid, 2'b00);
    step();
    arb_en = 1'b1;
    step();
    @(negedge clk);
    check("resume halted", halted, 1'b0);
    check("resume req_ready", req_ready, 2'b01);
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    repeat (4) step();

    // Reset between a read accept and its response.
    step();
    drive(2'b01, 2'b00, 6'd1, 6'd0, 16'h5A5A, 16'h0);
    @(negedge clk);
    check("rstmid accept req_ready", req_ready, 2'b01);
    step();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstmid");
    step();
    rst = 1'b0;
    drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    @(negedge clk);
    check("rstmid r2 rsp_valid", rsp_valid, 2'b00);
    step();
    @(negedge clk);
    check("rstmid r3 rsp_valid", rsp_valid, 2'b00);
    step();
    @(negedge clk);
    check("rstmid r4 rsp_valid", rsp_valid, 2'b00);
    step();
    drive(2'b11, 2'b00, 6'd1, 6'd2, 16'h0, 16'h0);
    @(negedge clk);
    check("post reset priority", req_ready, 2'b01);
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
